seg7_scan: RTL

Four-digit seven-segment scanner for the Basys3 display, consuming the two 8-bit binary fields produced by the display controller (`disp_l` on the left pair of digits, `disp_r` on the right pair). A sequential double-dabble converter turns each field into two BCD digits. A refresh counter time-multiplexes the common-anode digits. All board-facing outputs are registered and active-low.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 79 +++++++
 rtl/seg7_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns,
// the BCD dash code and the converter state encoding.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } conv_state_t;

  // BCD code used for "out of range"; rendered as a dash
  localparam logic [3:0] BCD_DASH = 4'hF;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Nibble to segment pattern; codes A-E are blank, F is a dash
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:     return SEG_0;
      4'd1:     return SEG_1;
      4'd2:     return SEG_2;
      4'd3:     return SEG_3;
      4'd4:     return SEG_4;
      4'd5:     return SEG_5;
      4'd6:     return SEG_6;
      4'd7:     return SEG_7;
      4'd8:     return SEG_8;
      4'd9:     return SEG_9;
      BCD_DASH: return SEG_DASH;
      default:  return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to a BCD nibble before each shift
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD (1 cycle), SHIFT (8 cycles),
// STORE (1 cycle), back-to-back with no idle gaps. The side bit selects
// which field the top feeds in and which BCD register the result goes to.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bin,
  output logic [7:0] bcd,
  output logic       store,
  output logic       side
);

  conv_state_t state, state_nxt;
  logic [7:0]  bin_sr;
  logic [7:0]  bcd_sr;
  logic [2:0]  bit_cnt;
  logic        oor;
  logic [3:0]  adj_hi, adj_lo;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic: fixed 10-cycle loop
  // NOTE: a default assignment ahead of the case keeps this block free of
  // inferred latches even if a state is added later.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 3'd7) state_nxt = ST_STORE;
      ST_STORE: state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Outputs: strobe in STORE, result forced to dash for values >= 100
  always_comb begin
    store = (state == ST_STORE);
    bcd   = oor ? {BCD_DASH, BCD_DASH} : bcd_sr;
  end

  assign adj_hi = add3(bcd_sr[7:4]);
  assign adj_lo = add3(bcd_sr[3:0]);

  // Datapath: sample in LOAD, add-3 then shift in SHIFT, flip side in STORE
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      oor     <= 1'b0;
      side    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          bin_sr  <= bin;
          bcd_sr  <= '0;
          bit_cnt <= '0;
          oor     <= (bin >= 8'd100);
        end
        ST_SHIFT: begin
          bcd_sr  <= {adj_hi[2:0], adj_lo, bin_sr[7]};
          bin_sr  <= {bin_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_STORE: side <= ~side;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit common-anode scanner for the Basys3 display. Converts disp_l
// and disp_r to BCD in turn and time-multiplexes the digits.
// Optional feature macro: SEG7_COLON_BLINK_EN (blinking dp on digit 2).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] disp_l,
  input  logic [7:0] disp_r,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              RW      = $clog2(DIGIT_CYCLES);
  localparam logic [RW-1:0]   REF_MAX = RW'(DIGIT_CYCLES - 1);

  if (DIGIT_CYCLES < 2) begin : g_bad_digit
    $error("DIGIT_CYCLES must be at least 2");
  end
  if (BLINK_CYCLES < 2) begin : g_bad_blink
    $error("BLINK_CYCLES must be at least 2");
  end

  logic [7:0]    conv_bin, conv_bcd;
  logic          conv_store, conv_side;
  logic [7:0]    bcd_l, bcd_r;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig_idx;
  logic [3:0]    nib;

  assign conv_bin = conv_side ? disp_l : disp_r;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .store (conv_store),
    .side  (conv_side)
  );

  // BCD holding registers, written on the converter's store strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_l <= 8'h00;
      bcd_r <= 8'h00;
    end else if (conv_store) begin
      if (conv_side) bcd_l <= conv_bcd;
      else           bcd_r <= conv_bcd;
    end
  end

  // Refresh counter; digit index advances on each wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  // Select the BCD nibble for the digit being scanned
  always_comb begin
    case (dig_idx)
      2'd0:    nib = bcd_r[3:0];
      2'd1:    nib = bcd_r[7:4];
      2'd2:    nib = bcd_l[3:0];
      default: nib = bcd_l[7:4];
    endcase
  end

  // Registered active-low anode and segment outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << dig_idx);
      seg <= seg_decode(nib);
    end
  end

`ifdef SEG7_COLON_BLINK_EN
  localparam int            BW       = $clog2(BLINK_CYCLES);
  localparam logic [BW-1:0] BLNK_MAX = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink;

  // Blink phase toggles every BLINK_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLNK_MAX) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Separator dot on digit 2 while the blink phase is high
  always_ff @(posedge clk) begin
    if (rst) dp <= 1'b1;
    else     dp <= ~((dig_idx == 2'd2) && blink);
  end
`else
  assign dp = 1'b1;
`endif

endmodule
